// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// width of the prescaler counter.
package countdown_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PRESCALER_W = 16;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Tick prescaler for the countdown timer: counts enabled cycles and raises a
// combinational tick on the last cycle of each PRESCALE-cycle window.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [PRESCALER_W-1:0] LAST = PRESCALER_W'(PRESCALE - 1);

    logic [PRESCALER_W-1:0] r_cnt;

    // Tick is only meaningful while counting is allowed.
    assign tick = run && (r_cnt == LAST);

    // Window counter: restarts on load, freezes while run is low, wraps on tick.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a one-cycle terminal-count pulse.
// Optional feature macro: AUTO_RELOAD_EN (reload the start value on expiry
// and keep running instead of stopping).
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             tc
);

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_next;
    logic             r_tc;
    logic             w_tc_next;
    logic             w_run;
    logic             w_tick;

    assign w_run = (r_state == ST_RUN) && enable;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .run   (w_run),
        .tick  (w_tick)
    );

    // State, count, reload and tc registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_reload <= w_reload_next;
            r_tc     <= w_tc_next;
        end
    end

    // Next-state logic: load beats tick; expiry either stops or reloads.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_reload_next = r_reload;
        w_tc_next     = 1'b0;
        if (load) begin
            w_reload_next = load_value;
            w_count_next  = load_value;
            w_state_next  = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
                w_count_next = r_count - 1'b1;
            end else if (r_count == WIDTH'(1)) begin
                w_tc_next    = 1'b1;
                w_count_next = AUTO_RELOAD ? r_reload : '0;
                w_state_next = AUTO_RELOAD ? ST_RUN : ST_IDLE;
            end else begin
                // A zero count in RUN cannot arise; fall back to idle.
                w_state_next = ST_IDLE;
            end
        end
    end

    assign count_out = r_count;
    assign busy      = (r_state == ST_RUN);
    assign tc        = r_tc;

endmodule
